load_store_unit: RTL

- Multi-cycle load/store stage directly downstream of the ALU.
- Consumes the ALU's effective-address result, the rs2 store data and the funct3 width code of L/S-type instructions.
- Runs one data-memory transaction over a req/ready handshake and returns the aligned, sign- or zero-extended load value for write-back.
- Asserts busy so the core stalls PC update until done.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: one data-memory transaction per request, with byte-lane
// formation and load extraction. Optional access timeout under LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_k;
    logic        r_mem_req, r_mem_we, r_busy, r_done, r_fault;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;
    logic [3:0]  r_mem_wstrb;
    logic [1:0]  r_cause;

    logic        w_req_nxt, w_we_nxt, w_done_nxt, w_fault_nxt, w_latch;
    logic [31:0] w_addr_nxt, w_wdata_nxt, w_rdata_nxt;
    logic [3:0]  w_wstrb_nxt;
    logic [1:0]  w_cause_nxt;
    logic        w_illegal, w_misaligned, w_timeout;
    logic [31:0] w_st_data, w_lane, w_ext;
    logic [3:0]  w_st_strb;

    // Request screening on the live inputs; only meaningful in IDLE with start.
    always_comb begin
        w_illegal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = is_store;
            default:                w_illegal = 1'b1;
        endcase
        w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        w_st_data = wdata;
        w_st_strb = 4'b1111;
        case (funct3[1:0])
            2'b00:   begin w_st_data = {4{wdata[7:0]}};  w_st_strb = 4'b0001 << addr[1:0]; end
            2'b01:   begin w_st_data = {2{wdata[15:0]}}; w_st_strb = 4'b0011 << addr[1:0]; end
            default: begin w_st_data = wdata;            w_st_strb = 4'b1111;              end
        endcase
    end

    assign w_lane = mem_rdata >> {r_k, 3'b000};
    always_comb begin
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_ext = {16'd0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_cnt <= 16'd0;
        else if (r_state != S_ACCESS) r_cnt <= 16'd0;
        else if (!mem_ready)          r_cnt <= r_cnt + 16'd1;
    end
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = 1'b0;
        w_we_nxt    = r_mem_we;
        w_addr_nxt  = r_mem_addr;
        w_wstrb_nxt = r_mem_wstrb;
        w_wdata_nxt = r_mem_wdata;
        w_rdata_nxt = r_rdata;
        w_done_nxt  = 1'b0;
        w_fault_nxt = 1'b0;
        w_cause_nxt = 2'b00;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_latch = 1'b1;
                if (w_illegal || w_misaligned) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_fault_nxt = 1'b1;
                    w_cause_nxt = w_illegal ? 2'b10 : 2'b01;
                end else begin
                    w_state_nxt = S_ACCESS;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = is_store;
                    w_addr_nxt  = {addr[31:2], 2'b00};
                    w_wstrb_nxt = is_store ? w_st_strb : 4'b0000;
                    w_wdata_nxt = w_st_data;
                end
            end
            S_ACCESS: begin
                // Ready on the timeout edge still completes normally.
                if (mem_ready || w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_wstrb_nxt = 4'b0000;
                    if (mem_ready && !r_is_store) w_rdata_nxt = w_ext;
                    if (!mem_ready) begin
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = 2'b11;
                    end
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_k         <= 2'b00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_cause     <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wstrb <= w_wstrb_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_fault     <= w_fault_nxt;
            r_cause     <= w_cause_nxt;
            if (w_latch) begin
                r_is_store <= is_store;
                r_funct3   <= funct3;
                r_k        <= addr[1:0];
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wstrb   = r_mem_wstrb;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign fault       = r_fault;
    assign fault_cause = r_cause;
endmodule
